// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divisor and the
// parity helper. Used by the transmitter and the matching receiver.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_tx_pkg;

    // 125 MHz system clock / 115200 baud
    localparam logic [15:0] BAUD_CNT_DEFAULT = 16'd1085;

    // Encodings are fixed so the receiver and any debug tooling agree on them
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity: the extra bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-write handshake and serial/status outputs of the UART transmitter.
interface uart_tx_if;
    logic       ip_flag;
    logic [7:0] ip_data;
    logic       tx;
    logic       busy;
    logic       full;

    modport master (output ip_flag, output ip_data, input tx, input busy, input full);
    modport slave  (input ip_flag, input ip_data, output tx, output busy, output full);
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO, 2**DEPTH_LOG2 entries. A push while full is dropped
// even if a pop happens on the same edge; a pop while empty is ignored.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [7:0]        wdata,
    input  logic              pop,
    output logic [7:0]        rdata,
    output logic              full,
    output logic              empty,
    output logic [DEPTH_LOG2:0] count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, one start and one stop bit, fed
// from a small byte FIFO. tx is registered one cycle behind the FSM state,
// so each bit still lasts exactly baud_cnt_max clocks.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit before stop).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [15:0] baud_cnt_max    = BAUD_CNT_DEFAULT,
    parameter int          fifo_depth_log2 = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    uart_state_e              state_q, state_d;
    logic [15:0]              baud_cnt_q, baud_cnt_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [7:0]               shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     bit_done;
    logic                     fifo_pop, fifo_empty, fifo_full;
    logic [7:0]               fifo_rdata;
    logic [fifo_depth_log2:0] fifo_count;
`ifdef UART_TX_PARITY_EN
    logic                     parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .DEPTH_LOG2(fifo_depth_log2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.ip_flag),
        .wdata (bus.ip_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_done = (baud_cnt_q == baud_cnt_max - 16'd1);

    // Next-state, bit timing, FIFO pop and line level for the following cycle
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_done ? 16'd0 : baud_cnt_q + 16'd1;
        end
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_d   = even_parity(fifo_rdata);
`endif
                    baud_cnt_d = 16'd0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_rdata);
`endif
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_q != ST_IDLE) || (fifo_count != '0);
    end

    // FSM, counters and registered outputs; reset parks the line idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // Frame data registers, only meaningful once the FSM has loaded them
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.full = fifo_full;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with a short baud divisor. Expected frames go into a
// scoreboard queue at write time; a line monitor decodes tx and compares.
module tb_uart_tx;

    localparam int B = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * B;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;
    exp_t sb_q[$];

    uart_tx_if bus();

    uart_tx #(
        .baud_cnt_max    (16'd16),
        .fifo_depth_log2 (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called #1 after an edge; leaves the bench #1 after the accepting edge
    task automatic write_byte(input logic [7:0] d, output int acc);
        bus.ip_flag = 1'b1;
        bus.ip_data = d;
        @(posedge clk); #1;
        acc = cyc;
        bus.ip_flag = 1'b0;
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((bus.busy || sb_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, int'(n < budget), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Line monitor: decode every frame, check timing, data, parity and stop
    initial begin : monitor
        logic             prev;
        logic [NBITS-1:0] bits;
        logic             stable;
        logic             aborted;
        int               s;
        exp_t             e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !bus.tx) begin
                s       = cyc;
                stable  = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                for (int k = 0; k < NBITS; k++) begin
                    for (int j = 0; j < B; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (j == 0) bits[k] = bus.tx;
                        else if (bus.tx !== bits[k]) stable = 1'b0;
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    frames_seen++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=0x%02h expected=none (start %0d)", bits[8:1], s);
                    end else begin
                        e = sb_q.pop_front();
                        check("frame_data", int'(bits[8:1]), int'(e.data));
                        check("frame_start_cycle", s, e.start);
                        check("bit_width_stable", int'(stable), 1);
                        check("stop_bit", int'(bits[NBITS-1]), 1);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", int'(bits[9]), int'(^e.data));
`endif
                    end
                end
            end
            prev = bus.tx;
        end
    end

    initial begin : stimulus
        int   acc;
        int   a1;
        int   base;
        int   seen_before;
        logic [7:0] burst [5];
        burst[0] = 8'h01; burst[1] = 8'h02; burst[2] = 8'h03;
        burst[3] = 8'h04; burst[4] = 8'h05;

        bus.ip_flag = 1'b0;
        bus.ip_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", int'(bus.tx), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_full", int'(bus.full), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 0x00 on an idle block: busy one edge after accept, tx two edges after
        write_byte(8'h00, acc);
        sb_q.push_back('{8'h00, acc + 2});
        check("busy_at_accept", int'(bus.busy), 0);
        check("tx_at_accept", int'(bus.tx), 1);
        @(posedge clk); #1;
        check("busy_accept_plus1", int'(bus.busy), 1);
        check("tx_accept_plus1", int'(bus.tx), 1);
        @(posedge clk); #1;
        check("tx_accept_plus2", int'(bus.tx), 0);
        wait_edge(acc + 1 + FRAME);
        check("busy_last_stop_edge", int'(bus.busy), 1);
        wait_edge(acc + 2 + FRAME);
        check("busy_after_stop", int'(bus.busy), 0);
        check("tx_idle_after_stop", int'(bus.tx), 1);
        wait_idle("idle_after_0x00", 4 * FRAME);

        // 0x55: alternating data bits
        write_byte(8'h55, acc);
        sb_q.push_back('{8'h55, acc + 2});
        wait_idle("idle_after_0x55", 4 * FRAME);

        // 0xA3: parity bit 0 when enabled
        write_byte(8'hA3, acc);
        sb_q.push_back('{8'hA3, acc + 2});
        wait_idle("idle_after_0xA3", 4 * FRAME);

        // Burst of five, then a sixth write while full which must be dropped
        a1 = 0;
        for (int i = 0; i < 5; i++) begin
            write_byte(burst[i], acc);
            if (i == 0) a1 = acc;
            sb_q.push_back('{burst[i], a1 + 2 + i * FRAME});
            if (i == 3) check("full_after_4th", int'(bus.full), 0);
            if (i == 4) check("full_after_5th", int'(bus.full), 1);
        end
        write_byte(8'h06, acc);
        check("full_after_drop", int'(bus.full), 1);
        @(posedge clk); #1;
        check("busy_in_burst", int'(bus.busy), 1);
        wait_idle("idle_after_burst", 7 * FRAME);
        check("full_after_burst", int'(bus.full), 0);

        // Reset in data bit 3 of 0xF0 with two more bytes queued
        write_byte(8'hF0, acc);
        base = acc;
        write_byte(8'h11, acc);
        write_byte(8'h22, acc);
        wait_edge(base + 2 + 4 * B + B / 2);
        check("tx_mid_frame", int'(bus.tx), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx", int'(bus.tx), 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_full", int'(bus.full), 0);
        seen_before = frames_seen;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        check("no_frames_after_reset", frames_seen, seen_before);
        check("tx_idle_after_reset", int'(bus.tx), 1);
        check("busy_idle_after_reset", int'(bus.busy), 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: baud_cnt_max, default 16'd1085, clock cycles per serial bit (125 MHz / 115200 baud).
REQ-002 SHALL have parameter: fifo_depth_log2, default 2, log2 of transmit FIFO depth (depth 4).
REQ-003 SHALL have port: clk  input  1  system clock, single clock domain, rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ip_flag  input  1  one-cycle write strobe for ip_data.
REQ-006 SHALL have port: ip_data  input  8  byte to transmit, sampled when ip_flag=1.
REQ-007 SHALL have port: tx  output  1  serial line, idle high.
REQ-008 SHALL have port: busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-009 SHALL have port: full  output  1  high when the FIFO holds fifo_depth_log2-derived depth entries.

Function
REQ-010 SHALL run FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-011 SHALL send frame: start bit 0, 8 data bits LSB first, optional parity, one stop bit 1.
REQ-012 SHALL hold every bit on tx for exactly baud_cnt_max clocks, baud counter 0..baud_cnt_max-1.
REQ-013 SHALL count data bits with a 3-bit index; leave DATA after index 7 completes.
REQ-014 SHALL write ip_data into the FIFO at an edge with ip_flag=1 and full=0.
REQ-015 SHALL silently drop a write at an edge with full=1, even if a pop occurs on that same edge.
REQ-016 SHALL pop the FIFO and latch the byte into a shift register when IDLE and FIFO non-empty, entering START.
REQ-017 SHALL drive tx=0 from the second rising edge after the edge that accepted a write into an empty, idle block.
REQ-018 SHALL, at STOP end with FIFO non-empty, pop and enter START directly (zero idle clocks between frames).
REQ-019 SHALL, at STOP end with FIFO empty, return to IDLE with tx=1.
REQ-020 SHALL register tx (no combinational path from ip_* to tx).
REQ-021 SHALL wrap FIFO read/write pointers modulo depth; count range 0..depth.
REQ-022 SHALL accept a simultaneous write and pop when not full; count stays unchanged.

Reset
REQ-023 SHALL on rst_n=0 immediately force tx=1, busy=0, full=0, state IDLE, counters 0, FIFO empty.
REQ-024 SHALL abort any frame in progress on reset mid-frame; discarded bytes are not resent.

Configuration
REQ-025 SHALL, with UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP; frame = 11 bit-times.
REQ-026 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely; frame = 10 bit-times.

Structure
REQ-027 SHALL place the FSM state encodings and the default baud constant 1085 in a shared package/include used with the receiver.
REQ-028 SHALL implement the FIFO as sub-module uart_tx_fifo (depth, push, pop, full, empty, count).

Verification
REQ-029 SHALL cover: baud_cnt_max=16, write 0x55 -> tx 0 for 16 clks, then 1,0,1,0,1,0,1,0 each 16 clks, then 1; 160 clks total (no macro).
REQ-030 SHALL cover: write 0xA3 with UART_TX_PARITY_EN -> data bits 1,1,0,0,0,1,0,1, parity bit 0, 176 clks total.
REQ-031 SHALL cover: 5 consecutive writes 0x01..0x05 while idle -> full=1 after 4th accepted pop/push balance, 0x05 dropped only if full at its edge; transmitted bytes in order, no gap between stop and next start.
REQ-032 SHALL cover: rst_n low at DATA bit 3 of 0xF0 with 2 bytes queued -> tx=1 immediately, busy=0, full=0; after release, no frames sent.
REQ-033 SHALL cover: write 0x00 on idle block -> tx falls exactly 2 edges after accept; busy rises 1 edge after accept, falls 1 edge after stop bit ends.
